// File: rtl/msg_tx.sv
// msg_tx: formats bot status messages (mnemonic, '-' separated fields, '#' terminator)
// and feeds them one byte at a time to the UART TX engine. Define MSG_TX_NEWLINE_EN to append 0Ah.
module msg_tx #(
   parameter int GAP_CYCLES     = 0,
   parameter int TIMEOUT_CYCLES = 0
) (
   input  logic       clk_50M,
   input  logic       rst,
   input  logic       send_req,
   input  logic [1:0] msg_type,
   input  logic [1:0] unit_sel,
   input  logic [1:0] block_num,
   input  logic       tx_done,
   output logic [7:0] tx_data,
   output logic       tx_start,
   output logic       busy,
   output logic       msg_done,
   output logic       err,
   output logic [2:0] state_dbg
);

   // Byte handshake: tx_start pulses one cycle with tx_data valid; tx_data then holds
   // until the engine returns a one-cycle tx_done, honoured only in WAIT after the launch cycle.

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_WAIT  = 3'd1,
      S_GAP   = 3'd2,
      S_START = 3'd3,
      S_DONE  = 3'd4,
      S_ERR   = 3'd5
   } state_t;

   localparam int CNT_MAX = (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
   localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);
   localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 2);

   function automatic logic [3:0] term_idx(input logic [1:0] t);
      logic [3:0] r;
      case (t)
         2'd0:       r = 4'd7;
         2'd1, 2'd2: r = 4'd10;
         default:    r = 4'd4;
      endcase
      return r;
   endfunction

   function automatic logic [3:0] last_idx(input logic [1:0] t);
      logic [3:0] r;
`ifdef MSG_TX_NEWLINE_EN
      r = term_idx(t) + 4'd1;
`else
      r = term_idx(t);
`endif
      return r;
   endfunction

   function automatic logic [7:0] unit_char(input logic [1:0] u);
      logic [7:0] r;
      case (u)
         2'd0:    r = 8'h45;
         2'd1:    r = 8'h43;
         2'd2:    r = 8'h52;
         default: r = 8'h53;
      endcase
      return r;
   endfunction

   // PBM and DBM share one layout; only the first mnemonic letter differs.
   function automatic logic [7:0] msg_byte(input logic [1:0] t, input logic [1:0] u,
                                           input logic [1:0] b, input logic [3:0] idx);
      logic [7:0] c;
      c = 8'h00;
      if (idx == term_idx(t)) c = 8'h23;
`ifdef MSG_TX_NEWLINE_EN
      else if (idx == term_idx(t) + 4'd1) c = 8'h0A;
`endif
      else if (t == 2'd3) begin
         case (idx)
            4'd0:    c = 8'h45;
            4'd1:    c = 8'h4E;
            4'd2:    c = 8'h44;
            4'd3:    c = 8'h2D;
            default: c = 8'h00;
         endcase
      end else begin
         case (idx)
            4'd0:    c = (t == 2'd0) ? 8'h49 : ((t == 2'd1) ? 8'h50 : 8'h44);
            4'd1:    c = (t == 2'd0) ? 8'h46 : 8'h42;
            4'd2:    c = 8'h4D;
            4'd3:    c = 8'h2D;
            4'd4:    c = unit_char(u);
            4'd5:    c = 8'h55;
            4'd6:    c = 8'h2D;
            4'd7:    c = 8'h42;
            4'd8:    c = 8'h31 + {6'd0, b};
            4'd9:    c = 8'h2D;
            default: c = 8'h00;
         endcase
      end
      return c;
   endfunction

   state_t           state_q, state_d;
   logic [3:0]       idx_q, idx_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       type_q, type_d;
   logic [1:0]       unit_q, unit_d;
   logic [1:0]       blk_q, blk_d;
   logic [7:0]       tx_data_q, tx_data_d;
   logic             tx_start_q, tx_start_d;
   logic             busy_q, busy_d;
   logic             msg_done_q, msg_done_d;
   logic             err_q, err_d;

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      cnt_d      = cnt_q;
      type_d     = type_q;
      unit_d     = unit_q;
      blk_d      = blk_q;
      tx_data_d  = tx_data_q;
      tx_start_d = 1'b0;
      busy_d     = busy_q;
      msg_done_d = 1'b0;
      err_d      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (send_req) begin
               type_d     = msg_type;
               unit_d     = unit_sel;
               blk_d      = block_num;
               idx_d      = 4'd0;
               cnt_d      = '0;
               tx_data_d  = msg_byte(msg_type, unit_sel, block_num, 4'd0);
               tx_start_d = 1'b1;
               busy_d     = 1'b1;
               state_d    = S_WAIT;
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q + 1'b1;
            if (tx_done && !tx_start_q) begin
               if (idx_q == last_idx(type_q)) begin
                  msg_done_d = 1'b1;
                  state_d    = S_DONE;
               end else begin
                  idx_d = idx_q + 4'd1;
                  cnt_d = '0;
                  // With no gap the next byte launches straight from WAIT to keep M+1 latency.
                  if (GAP_CYCLES == 0) begin
                     tx_data_d  = msg_byte(type_q, unit_q, blk_q, idx_q + 4'd1);
                     tx_start_d = 1'b1;
                  end else if (GAP_CYCLES == 1) begin
                     state_d = S_START;
                  end else begin
                     state_d = S_GAP;
                  end
               end
            end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST)) begin
               err_d   = 1'b1;
               state_d = S_ERR;
            end
         end
         S_GAP: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == GAP_LAST) state_d = S_START;
         end
         S_START: begin
            tx_data_d  = msg_byte(type_q, unit_q, blk_q, idx_q);
            tx_start_d = 1'b1;
            cnt_d      = '0;
            state_d    = S_WAIT;
         end
         S_DONE, S_ERR: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_50M) begin
      if (rst) begin
         state_q    <= S_IDLE;
         idx_q      <= 4'd0;
         cnt_q      <= '0;
         type_q     <= 2'd0;
         unit_q     <= 2'd0;
         blk_q      <= 2'd0;
         tx_data_q  <= 8'h00;
         tx_start_q <= 1'b0;
         busy_q     <= 1'b0;
         msg_done_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         cnt_q      <= cnt_d;
         type_q     <= type_d;
         unit_q     <= unit_d;
         blk_q      <= blk_d;
         tx_data_q  <= tx_data_d;
         tx_start_q <= tx_start_d;
         busy_q     <= busy_d;
         msg_done_q <= msg_done_d;
         err_q      <= err_d;
      end
   end

   assign tx_data   = tx_data_q;
   assign tx_start  = tx_start_q;
   assign busy      = busy_q;
   assign msg_done  = msg_done_q;
   assign err       = err_q;
   assign state_dbg = state_q;

endmodule
